cpu_bus_arbiter: RTL and testbench

//  N-master to 1-slave arbiter for the CPU data-bus protocol (request/address/write/wstrb/wdata/rdata/ack).

---
 rtl/cpu_bus_arbiter_pkg.sv | 21 ++
 rtl/cpu_bus_arbiter_if.sv | 53 +++++
 rtl/cpu_bus_arbiter_rr_picker.sv | 32 +++
 rtl/cpu_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and constants for the CPU data-bus arbiter.
// Bus field widths, FSM state encoding and the timeout error data word.
package cpu_bus_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERROR_RDATA = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // A disabled timeout still needs a legal 1-bit counter.
  function automatic int cnt_width(int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Master-side and slave-side signal bundle of the CPU bus arbiter.
// Modports: arb (the arbiter), master (requesters), slave (memory).
interface cpu_bus_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32
);
  import cpu_bus_arbiter_pkg::*;

  localparam int IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]        m_request;
  logic [NUM_MASTERS*ADDR_W-1:0] m_address;
  logic [NUM_MASTERS-1:0]        m_write;
  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]        m_ack;
  logic                          m_error;

  logic                          s_request;
  logic [ADDR_W-1:0]             s_address;
  logic                          s_write;
  logic [STRB_W-1:0]             s_wstrb;
  logic [DATA_W-1:0]             s_wdata;
  logic [DATA_W-1:0]             s_rdata;
  logic                          s_ack;

  logic [IW-1:0]                 grant_id;

  modport arb (
    input  m_request, m_address, m_write,
    input  m_wstrb, m_wdata,
    output m_rdata, m_ack, m_error,
    output s_request, s_address, s_write,
    output s_wstrb, s_wdata,
    input  s_rdata, s_ack,
    output grant_id
  );

  modport master (
    output m_request, m_address, m_write,
    output m_wstrb, m_wdata,
    input  m_rdata, m_ack, m_error,
    input  grant_id
  );

  modport slave (
    input  s_request, s_address, s_write,
    input  s_wstrb, s_wdata,
    output s_rdata, s_ack
  );

endinterface

// File: rtl/cpu_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping; returns one-hot grant, its index and an any-request flag.
module cpu_bus_arbiter_rr_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// N-master to 1-slave CPU data-bus arbiter: round-robin, one
// outstanding transaction, per-transaction timeout with error ack.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clock,
  input  logic           reset,
  cpu_bus_arbiter_if.arb bus
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TMO_LAST =
    TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_MASTERS - 1);

  arb_state_e state_q, state_d;

  logic [IW-1:0]          rr_q, rr_d;
  logic [IW-1:0]          gid_q, gid_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   sreq_q, sreq_d;
  logic [ADDR_W-1:0]      saddr_q, saddr_d;
  logic                   swr_q, swr_d;
  logic [STRB_W-1:0]      sstrb_q, sstrb_d;
  logic [DATA_W-1:0]      swd_q, swd_d;

  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic                   err_q, err_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;

  cpu_bus_arbiter_rr_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req (bus.m_request),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      sreq_q  <= 1'b0;
      saddr_q <= '0;
      swr_q   <= 1'b0;
      sstrb_q <= '0;
      swd_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      sreq_q  <= sreq_d;
      saddr_q <= saddr_d;
      swr_q   <= swr_d;
      sstrb_q <= sstrb_d;
      swd_q   <= swd_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    sreq_d  = sreq_q;
    saddr_d = saddr_q;
    swr_d   = swr_q;
    sstrb_d = sstrb_q;
    swd_d   = swd_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gid_d   = pick_idx;
          cnt_d   = '0;
          sreq_d  = 1'b1;
          state_d = ST_BUSY;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_gnt[i]) begin
              saddr_d = bus.m_address[i*ADDR_W +: ADDR_W];
              swr_d   = bus.m_write[i];
              sstrb_d = bus.m_wstrb[i*STRB_W +: STRB_W];
              swd_d   = bus.m_wdata[i*DATA_W +: DATA_W];
            end
          end
        end
      end

      ST_BUSY: begin
        if (TMO_EN) cnt_d = cnt_q + 1'b1;
        // A slave ack on the timeout cycle still completes normally.
        if (bus.s_ack) begin
          rdata_d     = swr_q ? '0 : bus.s_rdata;
          ack_d[gid_q] = 1'b1;
          sreq_d      = 1'b0;
          state_d     = ST_RESP;
        end else if (TMO_EN && cnt_q == TMO_LAST) begin
          rdata_d      = ERROR_RDATA;
          ack_d[gid_q] = 1'b1;
          err_d        = 1'b1;
          sreq_d       = 1'b0;
          state_d      = ST_RESP;
        end
      end

      ST_RESP: begin
        rr_d    = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.s_request = sreq_q;
  assign bus.s_address = saddr_q;
  assign bus.s_write   = swr_q;
  assign bus.s_wstrb   = sstrb_q;
  assign bus.s_wdata   = swd_q;
  assign bus.m_rdata   = rdata_q;
  assign bus.m_ack     = ack_q;
  assign bus.m_error   = err_q;
  assign bus.grant_id  = gid_q;

  // A granted master may not withdraw before its ack.
  a_hold_req: assert property (
    @(posedge clock) disable iff (reset)
    (state_q == ST_BUSY) |-> bus.m_request[gid_q]
  );

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed plus randomized bench for cpu_bus_arbiter, checked against
// a transaction-level round-robin/timeout model.
module tb_cpu_bus_arbiter;
  import cpu_bus_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int TMO = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  cpu_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW)) bus ();

  cpu_bus_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_ack = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic [AW-1:0] ma [N];
  logic          mw [N];
  logic [3:0]    ms [N];
  logic [31:0]   md [N];
  logic [N-1:0]  mreq;
  int            ptr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.m_request[i]         = mreq[i];
      bus.m_address[i*AW +: AW] = ma[i];
      bus.m_write[i]           = mw[i];
      bus.m_wstrb[i*4 +: 4]    = ms[i];
      bus.m_wdata[i*32 +: 32]  = md[i];
    end
  endtask

  task automatic set_m(int i, logic [AW-1:0] a, logic w,
                       logic [3:0] s, logic [31:0] d);
    ma[i] = a;
    mw[i] = w;
    ms[i] = s;
    md[i] = d;
  endtask

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk_idle_outs(string tag);
    chk({tag, ".sreq"}, bus.s_request, 0);
    chk({tag, ".ack"},  bus.m_ack, 0);
    chk({tag, ".err"},  bus.m_error, 0);
  endtask

  // d < TMO: slave acks in BUSY cycle d; otherwise never.
  task automatic txn(string tag, int d, int exp_n,
                     logic [31:0] rd, output int w);
    int n;
    int busy;
    int unsigned t0;
    bit to;
    w = pick(mreq, ptr);
    n = 0;
    while (bus.s_request !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".sreq_up"}, bus.s_request, 1);
    if (exp_n >= 0) chk({tag, ".lat"}, n, exp_n);
    chk({tag, ".gid"},   bus.grant_id, w);
    chk({tag, ".saddr"}, bus.s_address, ma[w]);
    chk({tag, ".swr"},   bus.s_write, mw[w]);
    chk({tag, ".sstrb"}, bus.s_wstrb, ms[w]);
    chk({tag, ".swd"},   bus.s_wdata, md[w]);
    t0 = cyc;
    to = (d >= TMO);
    busy = to ? TMO : d + 1;
    for (int k = 0; k < busy; k++) begin
      chk({tag, ".busy_ack"}, bus.m_ack, 0);
      chk({tag, ".busy_sa"}, bus.s_address, ma[w]);
      if (!to && k == d) begin
        bus.s_rdata = rd;
        bus.s_ack   = 1'b1;
      end
      step();
      bus.s_ack = 1'b0;
    end
    chk({tag, ".ack_lat"}, cyc - t0, busy);
    chk({tag, ".ack"},  bus.m_ack, 1 << w);
    chk({tag, ".err"},  bus.m_error, to);
    chk({tag, ".rdata"}, bus.m_rdata, (to || mw[w]) ? 0 : rd);
    chk({tag, ".sreq_dn"}, bus.s_request, 0);
    last_ack = cyc;
    ptr = (w + 1) % N;
  endtask

  initial begin
    int w;
    int unsigned a1;

    mreq = '0;
    ptr  = 0;
    for (int i = 0; i < N; i++) set_m(i, '0, 1'b0, '0, '0);
    drive();
    bus.s_ack   = 1'b0;
    bus.s_rdata = '0;

    // reset state
    reset = 1'b1;
    repeat (3) step();
    chk_idle_outs("rst");
    chk("rst.gid",   bus.grant_id, 0);
    chk("rst.saddr", bus.s_address, 0);
    chk("rst.rdata", bus.m_rdata, 0);
    reset = 1'b0;
    step();

    // single read from m0
    set_m(0, 32'h1000, 1'b0, 4'hF, 32'h0);
    mreq = 3'b001;
    drive();
    txn("rd", 2, 1, 32'hCAFEF00D, w);
    mreq = '0;
    drive();
    step();
    chk_idle_outs("rd.idle");

    // reset while BUSY
    set_m(2, 32'h3000, 1'b0, 4'hF, 32'h0);
    mreq = 3'b100;
    drive();
    step();
    chk("rb.sreq", bus.s_request, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mreq = '0;
    drive();
    ptr = 0;
    chk_idle_outs("rb");
    chk("rb.gid",   bus.grant_id, 0);
    chk("rb.saddr", bus.s_address, 0);
    for (int k = 0; k < 5; k++) begin
      chk("rb.noack", bus.m_ack, 0);
      step();
    end

    // fairness with continuous requests and immediate acks
    for (int i = 0; i < N; i++)
      set_m(i, 32'h4000 + i * 4, 1'b0, 4'hF, 32'h0);
    mreq = 3'b111;
    drive();
    for (int k = 0; k < 6; k++) begin
      a1 = last_ack;
      txn("fair", 0, (k == 0) ? 1 : 2, $urandom, w);
      chk("fair.order", w, k % N);
      if (k > 0) chk("fair.gap", last_ack - a1, 3);
    end
    mreq = '0;
    drive();
    step();

    // write from m2 while m0 idle
    set_m(2, 32'h2004, 1'b1, 4'b0110, 32'h12345678);
    mreq = 3'b100;
    drive();
    txn("wr", 1, 1, 32'hDEADBEEF, w);
    chk("wr.who", w, 2);
    mreq = '0;
    drive();
    step();

    // timeout, then a late slave ack
    set_m(1, 32'h5000, 1'b0, 4'hF, 32'h0);
    mreq = 3'b010;
    drive();
    txn("tmo", TMO, 1, 32'h11111111, w);
    mreq = '0;
    drive();
    step();
    step();
    bus.s_rdata = 32'h99999999;
    bus.s_ack   = 1'b1;
    step();
    bus.s_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_idle_outs("late");
      step();
    end

    set_m(0, 32'h6000, 1'b0, 4'hF, 32'h0);
    mreq = 3'b001;
    drive();
    txn("after", 1, 1, 32'h0BADCAFE, w);
    mreq = '0;
    drive();
    step();

    // ack on the timeout cycle
    mreq = 3'b001;
    drive();
    txn("edge", TMO - 1, 1, 32'h55AA55AA, w);

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++)
        set_m(i, $urandom, 1'($urandom), 4'($urandom), $urandom);
      mreq = 3'($urandom_range(1, 7));
      drive();
      txn("rnd", $urandom_range(0, 5), 2, $urandom, w);
    end

    mreq = '0;
    drive();
    repeat (2) step();
    chk_idle_outs("end");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
